// File: rtl/iob_mem_bist.sv
// Built-in self-test master for the IOb native memory path: writes and/or reads a window of words
// with pattern seed+index and reports pass, error count and first failing address. Option: IOB_MEM_BIST_INV_EN.
module iob_mem_bist #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 32,
  parameter int N_WORDS   = 16,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_W-1:0]     seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_W-1:0]     first_err_addr_o,
  output logic                  iob_valid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_rvalid_i,
  input  logic                  iob_ready_i,
  output logic                  invalidate_o,
  input  logic                  wtb_empty_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = 17;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_WORDS - 1);
  // Last count value before the counter would reach 2^TIMEOUT_W - 1.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~TIMEOUT_W'(1);
  localparam logic [1:0]           MODE_RD  = 2'd0;
  localparam logic [1:0]           MODE_WO  = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_FLUSH, S_RD_REQ, S_RD_WAIT, S_DONE} state_t;

  state_t                 state;
  logic [1:0]             mode_q;
  logic [DATA_W-1:0]      seed_q;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic [TIMEOUT_W-1:0]   tmo_cnt;
  logic [DATA_W-1:0]      exp_data;
  logic                   rd_mismatch;
  logic                   last_word;
  logic                   no_err;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
    return ADDR_W'(BASE_ADDR) + (ADDR_W'(i) << OFF_W);
  endfunction

  assign idx_nxt     = idx + IDX_W'(1);
  assign exp_data    = seed_q + DATA_W'(idx);
  assign rd_mismatch = iob_rdata_i != exp_data;
  assign last_word   = idx == LAST_IDX;
  assign no_err      = err_cnt_o == '0;

`ifndef IOB_MEM_BIST_INV_EN
  logic unused_wtb;
  assign unused_wtb = wtb_empty_i;
`endif

  // NOTE: every register here is updated with <= so all branches see pre-edge values of
  // err_cnt_o, idx and friends regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state            <= S_IDLE;
      mode_q           <= '0;
      seed_q           <= '0;
      idx              <= '0;
      tmo_cnt          <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      iob_valid_o      <= 1'b0;
      iob_addr_o       <= '0;
      iob_wdata_o      <= '0;
      iob_wstrb_o      <= '0;
      invalidate_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            mode_q           <= mode_i;
            seed_q           <= seed_i;
            idx              <= '0;
            err_cnt_o        <= '0;
            timeout_o        <= 1'b0;
            first_err_addr_o <= '0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            busy_o           <= 1'b1;
            iob_valid_o      <= 1'b1;
            iob_addr_o       <= addr_of('0);
            if (mode_i == MODE_RD) begin
              state       <= S_RD_REQ;
              iob_wdata_o <= '0;
              iob_wstrb_o <= '0;
            end else begin
              state       <= S_WR_REQ;
              iob_wdata_o <= seed_i;
              iob_wstrb_o <= '1;
            end
          end
        end
        S_WR_REQ: begin
          if (iob_ready_i) begin
            if (last_word) begin
              iob_valid_o <= 1'b0;
              idx         <= '0;
              if (mode_q == MODE_WO) begin
                state  <= S_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= no_err & ~timeout_o;
              end else begin
                state <= S_FLUSH;
              end
            end else begin
              idx         <= idx_nxt;
              iob_addr_o  <= addr_of(idx_nxt);
              iob_wdata_o <= seed_q + DATA_W'(idx_nxt);
            end
          end
        end
        S_FLUSH: begin
`ifdef IOB_MEM_BIST_INV_EN
          // Invalidate only once the write-through buffer has drained, so reads hit backing RAM.
          if (invalidate_o) begin
            invalidate_o <= 1'b0;
            state        <= S_RD_REQ;
            iob_valid_o  <= 1'b1;
            iob_addr_o   <= addr_of(idx);
            iob_wdata_o  <= '0;
            iob_wstrb_o  <= '0;
          end else if (wtb_empty_i) begin
            invalidate_o <= 1'b1;
          end
`else
          state       <= S_RD_REQ;
          iob_valid_o <= 1'b1;
          iob_addr_o  <= addr_of(idx);
          iob_wdata_o <= '0;
          iob_wstrb_o <= '0;
`endif
        end
        S_RD_REQ: begin
          if (iob_ready_i) begin
            iob_valid_o <= 1'b0;
            tmo_cnt     <= '0;
            state       <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (iob_rvalid_i) begin
            if (rd_mismatch) begin
              if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
              if (no_err) first_err_addr_o <= iob_addr_o;
            end
            if (last_word) begin
              state  <= S_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= ~rd_mismatch & no_err & ~timeout_o;
            end else begin
              idx         <= idx_nxt;
              state       <= S_RD_REQ;
              iob_valid_o <= 1'b1;
              iob_addr_o  <= addr_of(idx_nxt);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_o <= 1'b1;
            if (no_err) first_err_addr_o <= iob_addr_o;
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_mem_bist.sv
// Directed self-checking bench for iob_mem_bist with a behavioural IOb memory, stall and
// response-suppression controls. Works with or without IOB_MEM_BIST_INV_EN.
module tb_iob_mem_bist;

  localparam int ADDR_W    = 22;
  localparam int DATA_W    = 32;
  localparam int STRB_W    = DATA_W / 8;
  localparam int TIMEOUT_W = 4;

  logic                clk_i       = 1'b0;
  logic                arst_i      = 1'b1;
  logic                start_i     = 1'b0;
  logic [1:0]          mode_i      = '0;
  logic [DATA_W-1:0]   seed_i      = '0;
  logic                busy_o, done_o, pass_o, timeout_o;
  logic [15:0]         err_cnt_o;
  logic [ADDR_W-1:0]   first_err_addr_o;
  logic                iob_valid_o;
  logic [ADDR_W-1:0]   iob_addr_o;
  logic [DATA_W-1:0]   iob_wdata_o;
  logic [STRB_W-1:0]   iob_wstrb_o;
  logic [DATA_W-1:0]   iob_rdata_i  = '0;
  logic                iob_rvalid_i = 1'b0;
  logic                iob_ready_i  = 1'b0;
  logic                invalidate_o;
  logic                wtb_empty_i  = 1'b1;

  always #5 clk_i = ~clk_i;

  iob_mem_bist #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_WORDS(16), .BASE_ADDR(0), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .start_i(start_i), .mode_i(mode_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_rdata_i(iob_rdata_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_ready_i(iob_ready_i), .invalidate_o(invalidate_o), .wtb_empty_i(wtb_empty_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model and bus monitor; driven mid-cycle so the DUT samples settled values.
  logic [DATA_W-1:0] mem [0:63];
  bit  stall_en = 1'b0, junk_rv = 1'b0, corrupt_en = 1'b0;
  int  supp_word = -1, stall_left = 0;
  bit  rd_pend = 1'b0, prev_pend = 1'b0, last_wr = 1'b0;
  int  rd_word = 0, stab_err = 0, wr_cnt = 0, rd_cnt = 0, wr_streak = 0;
  int  inv_cnt = 0, inv_cyc = 0, supp_acc_cyc = 0;
  logic [ADDR_W-1:0] sv_addr  = '0;
  logic [DATA_W-1:0] sv_wdata = '0;
  logic [STRB_W-1:0] sv_wstrb = '0;

  always @(negedge clk_i) begin
    logic acc, wr_acc;
    int   w;
    if (prev_pend && {iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o} !== {1'b1, sv_addr, sv_wdata, sv_wstrb})
      stab_err++;
    if (invalidate_o === 1'b1) begin
      inv_cnt++;
      inv_cyc = cyc;
    end
    iob_rvalid_i = 1'b0;
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (rd_word != supp_word) begin
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = (corrupt_en && rd_word == 3) ? 32'hDEADBEEF : mem[rd_word];
      end
    end
    if (!stall_en) iob_ready_i = 1'b1;
    else if (stall_left > 0) begin
      iob_ready_i = 1'b0;
      stall_left--;
    end else begin
      iob_ready_i = 1'b1;
      stall_left  = $urandom_range(0, 5);
    end
    acc    = (iob_valid_o === 1'b1) && iob_ready_i;
    wr_acc = acc && (iob_wstrb_o != '0);
    w      = int'(iob_addr_o[7:2]);
    if (wr_acc) begin
      mem[w] = iob_wdata_o;
      wr_cnt++;
    end else if (acc) begin
      rd_pend = 1'b1;
      rd_word = w;
      rd_cnt++;
      if (w == supp_word) supp_acc_cyc = cyc;
    end
    wr_streak = wr_acc ? (last_wr ? wr_streak + 1 : 1) : wr_streak;
    last_wr   = wr_acc;
    if (acc && junk_rv && !iob_rvalid_i) begin
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = 32'hBAD0BAD0;
    end
    prev_pend = (iob_valid_o === 1'b1) && !iob_ready_i;
    sv_addr   = iob_addr_o;
    sv_wdata  = iob_wdata_o;
    sv_wstrb  = iob_wstrb_o;
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic start(input logic [1:0] m, input logic [DATA_W-1:0] s);
    start_i = 1'b1;
    mode_i  = m;
    seed_i  = s;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, output int lat);
    bit ok = 1'b0;
    lat = 0;
    for (int k = 0; k < 400; k++) begin
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_done: done_o=%b after 400 cycles, want 1", name, done_o);
    end
  endtask

  task automatic run(input string name, input logic [1:0] m, input logic [DATA_W-1:0] s, output int lat);
    start(m, s);
    wait_done(name, lat);
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({busy_o, done_o, pass_o, timeout_o, iob_valid_o, invalidate_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000", {busy_o, done_o, pass_o, timeout_o, iob_valid_o, invalidate_o});
    end
    n_cmp++;
    if ({err_cnt_o, first_err_addr_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_err: err_cnt=%h first=%h want 0", err_cnt_o, first_err_addr_o);
    end
    n_cmp++;
    if ({iob_addr_o, iob_wdata_o, iob_wstrb_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: addr=%h wdata=%h wstrb=%h want 0", iob_addr_o, iob_wdata_o, iob_wstrb_o);
    end
    arst_i = 1'b0;
    tick();
  endtask

  task automatic test_fill_check();
    int lat, wr0, rd0;
    bit bad_word = 1'b0;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    start(2'd2, 32'h0);
    n_cmp++;
    if ({busy_o, iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o} !== {2'b11, 22'h0, 32'h0, 4'hF}) begin
      n_bad++;
      $display("FAIL start_req: busy=%b valid=%b addr=%h wdata=%h wstrb=%h want 1 1 0 0 f",
               busy_o, iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o);
    end
    wait_done("fill", lat);
    n_cmp++;
    if (lat !== 16) begin
      n_bad++;
      $display("FAIL fill_latency: done after %0d cycles, want 16", lat);
    end
    n_cmp++;
    if ({wr_cnt - wr0, rd_cnt - rd0, pass_o, busy_o} !== {32'd16, 32'd0, 2'b10}) begin
      n_bad++;
      $display("FAIL fill_counts: writes=%0d reads=%0d pass=%b busy=%b want 16 0 1 0", wr_cnt - wr0, rd_cnt - rd0, pass_o, busy_o);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem[i] !== 32'(i)) begin
        n_bad++;
        bad_word = 1'b1;
        $display("FAIL fill_word%0d: mem=%h want %h", i, mem[i], 32'(i));
      end
    end
    run("check", 2'd0, 32'h0, lat);
    n_cmp++;
    if ({pass_o, timeout_o, err_cnt_o, first_err_addr_o} !== {2'b10, 16'd0, 22'h0}) begin
      n_bad++;
      $display("FAIL check_result: pass=%b timeout=%b err=%0d first=%h want 1 0 0 0", pass_o, timeout_o, err_cnt_o, first_err_addr_o);
    end
  endtask

  task automatic test_write_readback();
    int lat, rd0;
    rd0 = rd_cnt;
    junk_rv = 1'b1;
    run("wrb", 2'd1, 32'hAABBCCDD, lat);
    junk_rv = 1'b0;
    n_cmp++;
    if (wr_streak !== 16) begin
      n_bad++;
      $display("FAIL wrb_streak: %0d consecutive writes, want 16", wr_streak);
    end
    n_cmp++;
    if (mem[8] !== 32'hAABBCCE5) begin
      n_bad++;
      $display("FAIL wrb_word8: mem=%h want aabbcce5", mem[8]);
    end
    n_cmp++;
    if ({pass_o, err_cnt_o, rd_cnt - rd0} !== {1'b1, 16'd0, 32'd16}) begin
      n_bad++;
      $display("FAIL wrb_result: pass=%b err=%0d reads=%0d want 1 0 16", pass_o, err_cnt_o, rd_cnt - rd0);
    end
  endtask

  task automatic test_corrupt();
    int lat;
    run("preload", 2'd2, 32'h0, lat);
    corrupt_en = 1'b1;
    run("corrupt", 2'd0, 32'h0, lat);
    corrupt_en = 1'b0;
    n_cmp++;
    if ({err_cnt_o, first_err_addr_o, pass_o, timeout_o} !== {16'd1, 22'hC, 2'b00}) begin
      n_bad++;
      $display("FAIL corrupt_result: err=%0d first=%h pass=%b timeout=%b want 1 c 0 0", err_cnt_o, first_err_addr_o, pass_o, timeout_o);
    end
  endtask

  task automatic test_stalls();
    int lat, s0;
    s0 = stab_err;
    stall_en = 1'b1;
    run("stall_wrb", 2'd1, 32'h12345678, lat);
    n_cmp++;
    if ({pass_o, err_cnt_o, mem[15]} !== {1'b1, 16'd0, 32'h12345687}) begin
      n_bad++;
      $display("FAIL stall_wrb: pass=%b err=%0d word15=%h want 1 0 12345687", pass_o, err_cnt_o, mem[15]);
    end
    corrupt_en = 1'b1;
    run("stall_corrupt", 2'd0, 32'h12345678, lat);
    corrupt_en = 1'b0;
    stall_en = 1'b0;
    n_cmp++;
    if ({err_cnt_o, first_err_addr_o, pass_o} !== {16'd1, 22'hC, 1'b0}) begin
      n_bad++;
      $display("FAIL stall_corrupt: err=%0d first=%h pass=%b want 1 c 0", err_cnt_o, first_err_addr_o, pass_o);
    end
    n_cmp++;
    if (stab_err - s0 !== 0) begin
      n_bad++;
      $display("FAIL stall_stable: %0d request changes while stalled, want 0", stab_err - s0);
    end
  endtask

  task automatic test_timeout();
    int lat;
    supp_word = 5;
    run("timeout", 2'd0, 32'h12345678, lat);
    supp_word = -1;
    n_cmp++;
    if ({timeout_o, first_err_addr_o, pass_o, err_cnt_o} !== {1'b1, 22'h14, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL timeout_result: timeout=%b first=%h pass=%b err=%0d want 1 14 0 0", timeout_o, first_err_addr_o, pass_o, err_cnt_o);
    end
    n_cmp++;
    if (cyc - (supp_acc_cyc + 1) !== 15) begin
      n_bad++;
      $display("FAIL timeout_latency: done %0d cycles after acceptance, want 15", cyc - (supp_acc_cyc + 1));
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    start(2'd1, 32'h55);
    repeat (6) tick();
    arst_i = 1'b1;
    tick();
    n_cmp++;
    if ({busy_o, done_o, pass_o, timeout_o, iob_valid_o, invalidate_o, err_cnt_o, first_err_addr_o} !== '0) begin
      n_bad++;
      $display("FAIL midreset_status: busy=%b done=%b pass=%b timeout=%b valid=%b inv=%b err=%h first=%h want all 0",
               busy_o, done_o, pass_o, timeout_o, iob_valid_o, invalidate_o, err_cnt_o, first_err_addr_o);
    end
    n_cmp++;
    if ({iob_addr_o, iob_wdata_o, iob_wstrb_o} !== '0) begin
      n_bad++;
      $display("FAIL midreset_bus: addr=%h wdata=%h wstrb=%h want 0", iob_addr_o, iob_wdata_o, iob_wstrb_o);
    end
    arst_i = 1'b0;
    tick();
    run("after_reset", 2'd1, 32'h0F0F0000, lat);
    n_cmp++;
    if ({pass_o, err_cnt_o, mem[7]} !== {1'b1, 16'd0, 32'h0F0F0007}) begin
      n_bad++;
      $display("FAIL after_reset: pass=%b err=%0d word7=%h want 1 0 0f0f0007", pass_o, err_cnt_o, mem[7]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, wr0, rd0;
    wr0 = wr_cnt;
    start(2'd1, 32'hFFFFFFF8);
    repeat (3) tick();
    // A start while busy must be ignored.
    start(2'd0, 32'h0);
    wait_done("wrap", lat);
    n_cmp++;
    if ({pass_o, mem[7], mem[8], mem[15], wr_cnt - wr0} !== {1'b1, 32'hFFFFFFFF, 32'h0, 32'h7, 32'd16}) begin
      n_bad++;
      $display("FAIL wrap_result: pass=%b w7=%h w8=%h w15=%h writes=%0d want 1 ffffffff 0 7 16",
               pass_o, mem[7], mem[8], mem[15], wr_cnt - wr0);
    end
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    start(2'd3, 32'h100);
    n_cmp++;
    if ({done_o, pass_o, busy_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL restart_clear: done=%b pass=%b busy=%b want 0 0 1", done_o, pass_o, busy_o);
    end
    wait_done("mode3", lat);
    n_cmp++;
    if ({pass_o, wr_cnt - wr0, rd_cnt - rd0, mem[15]} !== {1'b1, 32'd16, 32'd16, 32'h10F}) begin
      n_bad++;
      $display("FAIL mode3_result: pass=%b writes=%0d reads=%0d w15=%h want 1 16 16 10f",
               pass_o, wr_cnt - wr0, rd_cnt - rd0, mem[15]);
    end
  endtask

  task automatic test_invalidate();
    int lat, wr0, inv0, wrise;
    wr0  = wr_cnt;
    inv0 = inv_cnt;
    wtb_empty_i = 1'b0;
    start(2'd1, 32'hC0DE0000);
    for (int k = 0; k < 100; k++) begin
      if (wr_cnt - wr0 >= 16) break;
      tick();
    end
    repeat (4) tick();
    wtb_empty_i = 1'b1;
    wrise = cyc;
    wait_done("inv", lat);
`ifdef IOB_MEM_BIST_INV_EN
    n_cmp++;
    if ({inv_cnt - inv0, 1'(inv_cyc > wrise)} !== {32'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL inv_pulse: %0d cycles high, last at %0d, wtb rose at %0d; want 1 cycle after rise", inv_cnt - inv0, inv_cyc, wrise);
    end
`else
    n_cmp++;
    if (inv_cnt - inv0 !== 0) begin
      n_bad++;
      $display("FAIL inv_idle: invalidate high %0d cycles, want 0", inv_cnt - inv0);
    end
`endif
    n_cmp++;
    if ({pass_o, err_cnt_o} !== {1'b1, 16'd0}) begin
      n_bad++;
      $display("FAIL inv_result: pass=%b err=%0d want 1 0", pass_o, err_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill_check();
    test_write_readback();
    test_corrupt();
    test_stalls();
    test_timeout();
    test_reset_midrun();
    test_back_to_back();
    test_invalidate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
